door_direction_detector: RTL and testbench
==========================================

// Module: door_direction_detector
// PURPOSE
//  Producer side of the occupancy-count interface: turns two raw light-barrier sensors
//  across a doorway into single-cycle ENTER / EXIT event pulses for the room occupancy
//  counter. Sensor A (sens_out) sits on the corridor side, sensor B (sens_in) on the room
//  side. Ordered sequence decoding rejects partial passes, backtracking and noise.
// PARAMETERS
//  DEB_CYCLES   4     consecutive equal synchronized samples before a sensor level is accepted
//  TIMEOUT_CYC  1000  max cycles a pass may stay in progress before being abandoned
//  TO_W         10    width of the timeout counter; must hold TIMEOUT_CYC
// PORTS
//  clk          in   1  single system clock, rising edge
//  rst_n        in   1  asynchronous active-low reset
//  sens_out     in   1  raw corridor-side beam, 1 = beam broken; asynchronous to clk
//  sens_in      in   1  raw room-side beam, 1 = beam broken; asynchronous to clk
//  enter_pulse  out  1  one-cycle pulse per completed corridor->room pass
//  exit_pulse   out  1  one-cycle pulse per completed room->corridor pass
//  abort_pulse  out  1  one-cycle pulse on timeout or ambiguous start
//  busy         out  1  1 whenever FSM is not IDLE
// BEHAVIOUR
//  Reset: all outputs 0; FSM = IDLE; sync flops, debounced levels (da, db) and counters = 0.
//  Input path: 2-flop synchronizer per sensor -> debouncer. da/db change only after
//   DEB_CYCLES consecutive identical synced samples; shorter glitches are ignored.
//   Raw edge to da/db change: 2 + DEB_CYCLES cycles.
//  FSM states (evaluated on da, db each cycle):
//   IDLE  : (1,0)->E_A; (0,1)->X_B; (1,1)->WAIT_CLR + abort_pulse; (0,0) stay
//   E_A   : (1,1)->E_AB; (0,0)->IDLE (walked away, no event); (0,1)->E_B
//   E_AB  : (0,1)->E_B; (1,0)->E_A (backtrack); (0,0)->IDLE, no event
//   E_B   : (0,0)->IDLE + enter_pulse; (1,1)->E_AB; (1,0)->E_A
//   X_B/X_BA/X_A: exact mirror of the E_* states with A/B swapped; X_A with (0,0)
//   -> IDLE + exit_pulse
//   WAIT_CLR: stay until (0,0) for one cycle -> IDLE; no events
//  Pulse timing: pulse registered; high exactly one cycle, the cycle after the FSM
//   leaves E_B or X_A. enter_pulse, exit_pulse and abort_pulse are mutually exclusive.
//  Timeout: counter clears on every state change and counts while in E_*/X_* states.
//   At TIMEOUT_CYC -> WAIT_CLR + abort_pulse. Not active in IDLE or WAIT_CLR.
//  busy = (state != IDLE), combinational from the state register.
//  Reset mid-pass: asynchronous return to IDLE, no pulse. After release a beam still
//   held broken is seen as a fresh start once debounced.
//  Back-to-back passes: a new pass may begin the cycle after IDLE is re-entered.
// STRUCTURE
//  door_pkg: state encoding localparams (IDLE, E_A, E_AB, E_B, X_B, X_BA, X_A, WAIT_CLR;
//   3-bit) and default DEB_CYCLES/TIMEOUT_CYC constants.
//  Sub-module: sensor_debounce (synchronizer + debounce counter, param DEB_CYCLES),
//   instantiated twice (A and B).
//  Top level: FSM, timeout counter, and output pulse registers only.
// TESTING
//  1 Reset: hold rst_n=0 with both beams broken -> all outputs 0; release -> WAIT_CLR +
//    abort_pulse after 2+DEB_CYCLES+1 cycles.
//  2 Enter: A=1; A=1,B=1; A=0,B=1; B=0, each held 20 cycles -> exactly one enter_pulse,
//    1 cycle wide; exit_pulse and abort_pulse stay 0.
//  3 Exit mirror: B, BA, A, clear -> one exit_pulse. Backtrack A, AB, A, clear -> no pulse.
//  4 Glitch: 3-cycle pulse on sens_out (DEB_CYCLES=4) -> no state change, busy stays 0.
//  5 Timeout: A held broken 1200 cycles -> abort_pulse at TIMEOUT_CYC after entering E_A;
//    busy stays 1 until A clears.
//  6 Reset mid-pass: assert rst_n=0 while in E_B -> immediate IDLE; no enter_pulse after
//    release once beams clear.

Source files
------------

// File: rtl/door_pkg.sv
// Shared state encoding and default timing constants for the doorway direction detector.
package door_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StEnterA  = 3'd1,
    StEnterAb = 3'd2,
    StEnterB  = 3'd3,
    StExitB   = 3'd4,
    StExitBa  = 3'd5,
    StExitA   = 3'd6,
    StWaitClr = 3'd7
  } door_state_e;

  localparam int unsigned DEB_CYCLES_DEF  = 4;
  localparam int unsigned TIMEOUT_CYC_DEF = 1000;
  localparam int unsigned TO_W_DEF        = 10;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer followed by a debouncer: the level follows the synced input only
// after DEB_CYCLES consecutive samples that disagree with the current level.
module sensor_debounce #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign level = level_q;

endmodule

// File: rtl/door_direction_detector.sv
// Decodes the ordered break/clear sequence of two doorway beams into enter/exit/abort
// pulses; A = corridor-side beam, B = room-side beam.
module door_direction_detector
  import door_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned TO_W        = TO_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sens_out,
  input  logic sens_in,
  output logic enter_pulse,
  output logic exit_pulse,
  output logic abort_pulse,
  output logic busy
);

  logic            da, db;
  logic [1:0]      ab;
  door_state_e     state_q, state_d;
  logic [TO_W-1:0] to_cnt_q;
  logic            enter_q, exit_q, abort_q;
  logic            enter_d, exit_d, abort_d;
  logic            in_pass;

  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (sens_out),
    .level (da)
  );

  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (sens_in),
    .level (db)
  );

  assign ab      = {da, db};
  assign in_pass = (state_q != StIdle) && (state_q != StWaitClr);

  always_comb begin
    state_d = state_q;
    enter_d = 1'b0;
    exit_d  = 1'b0;
    abort_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        case (ab)
          2'b10:   state_d = StEnterA;
          2'b01:   state_d = StExitB;
          2'b11: begin
            state_d = StWaitClr;
            abort_d = 1'b1;
          end
          default: ;
        endcase
      end
      StEnterA: begin
        case (ab)
          2'b11:   state_d = StEnterAb;
          2'b01:   state_d = StEnterB;
          2'b00:   state_d = StIdle;
          default: ;
        endcase
      end
      StEnterAb: begin
        case (ab)
          2'b01:   state_d = StEnterB;
          2'b10:   state_d = StEnterA;
          2'b00:   state_d = StIdle;
          default: ;
        endcase
      end
      StEnterB: begin
        case (ab)
          2'b00: begin
            state_d = StIdle;
            enter_d = 1'b1;
          end
          2'b11:   state_d = StEnterAb;
          2'b10:   state_d = StEnterA;
          default: ;
        endcase
      end
      StExitB: begin
        case (ab)
          2'b11:   state_d = StExitBa;
          2'b10:   state_d = StExitA;
          2'b00:   state_d = StIdle;
          default: ;
        endcase
      end
      StExitBa: begin
        case (ab)
          2'b10:   state_d = StExitA;
          2'b01:   state_d = StExitB;
          2'b00:   state_d = StIdle;
          default: ;
        endcase
      end
      StExitA: begin
        case (ab)
          2'b00: begin
            state_d = StIdle;
            exit_d  = 1'b1;
          end
          2'b11:   state_d = StExitBa;
          2'b01:   state_d = StExitB;
          default: ;
        endcase
      end
      StWaitClr: begin
        if (ab == 2'b00) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // A real transition always wins over an expiring timeout in the same cycle.
    if (in_pass && (state_d == state_q) && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1))) begin
      state_d = StWaitClr;
      abort_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      to_cnt_q <= '0;
      enter_q  <= 1'b0;
      exit_q   <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      enter_q <= enter_d;
      exit_q  <= exit_d;
      abort_q <= abort_d;
      if ((state_d != state_q) || !in_pass) begin
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
    end
  end

  assign enter_pulse = enter_q;
  assign exit_pulse  = exit_q;
  assign abort_pulse = abort_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_door_direction_detector.sv
// Directed and randomized beam sequences checked cycle by cycle against a pattern-level
// model of a doorway pass (direction, current beam pattern, age in that pattern).
module tb_door_direction_detector;

  localparam int DEB = 4;
  localparam int TIMEOUT = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sens_out = 1'b0;
  logic sens_in = 1'b0;
  logic enter_pulse, exit_pulse, abort_pulse, busy;

  int vectors = 0;
  int miscompares = 0;
  int n_enter = 0, n_exit = 0, n_abort = 0, n_busy = 0;

  // Model state: sync pipeline + run-length debounce, then a pass described by its pattern.
  logic m_s1 [2];
  logic m_s2 [2];
  logic m_lat[2];
  int   m_run[2];
  logic m_da [2];
  int   m_mode;       // 0 idle, 1 pass in progress, 2 waiting for both beams clear
  logic m_dir_enter;
  logic [1:0] m_pat;
  int   m_age;
  logic m_enter, m_exit, m_abort;

  door_direction_detector dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sens_out    (sens_out),
    .sens_in     (sens_in),
    .enter_pulse (enter_pulse),
    .exit_pulse  (exit_pulse),
    .abort_pulse (abort_pulse),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_lat[i] = 1'b0; m_run[i] = DEB; m_da[i] = 1'b0;
    end
    m_mode = 0; m_dir_enter = 1'b0; m_pat = 2'b00; m_age = 0;
    m_enter = 1'b0; m_exit = 1'b0; m_abort = 1'b0;
  endtask

  task automatic model_edge(input logic a, input logic b);
    logic [1:0] p;
    p = {m_da[0], m_da[1]};
    m_enter = 1'b0; m_exit = 1'b0; m_abort = 1'b0;
    case (m_mode)
      0: begin
        if (p == 2'b11) begin
          m_mode = 2; m_abort = 1'b1;
        end else if (p != 2'b00) begin
          m_mode = 1; m_dir_enter = (p == 2'b10); m_pat = p; m_age = 0;
        end
      end
      1: begin
        if (p != m_pat) begin
          if (p == 2'b00) begin
            // Completed only if the last beam seen is the far-side one for this direction.
            if (m_dir_enter && m_pat == 2'b01) m_enter = 1'b1;
            if (!m_dir_enter && m_pat == 2'b10) m_exit = 1'b1;
            m_mode = 0;
          end else begin
            m_pat = p; m_age = 0;
          end
        end else begin
          m_age++;
          if (m_age == TIMEOUT) begin
            m_mode = 2; m_abort = 1'b1;
          end
        end
      end
      default: if (p == 2'b00) m_mode = 0;
    endcase
    for (int i = 0; i < 2; i++) begin
      if (m_s2[i] == m_lat[i]) begin
        if (m_run[i] < DEB) m_run[i]++;
      end else begin
        m_lat[i] = m_s2[i]; m_run[i] = 1;
      end
      if (m_run[i] >= DEB && m_lat[i] != m_da[i]) m_da[i] = m_lat[i];
      m_s2[i] = m_s1[i];
    end
    m_s1[0] = a;
    m_s1[1] = b;
  endtask

  task automatic check();
    vectors++;
    n_enter += int'(enter_pulse);
    n_exit  += int'(exit_pulse);
    n_abort += int'(abort_pulse);
    n_busy  += int'(busy);
    assert (enter_pulse === m_enter) else begin
      miscompares++;
      $error("FAIL enter_pulse t=%0t observed=%b expected=%b", $time, enter_pulse, m_enter);
    end
    assert (exit_pulse === m_exit) else begin
      miscompares++;
      $error("FAIL exit_pulse t=%0t observed=%b expected=%b", $time, exit_pulse, m_exit);
    end
    assert (abort_pulse === m_abort) else begin
      miscompares++;
      $error("FAIL abort_pulse t=%0t observed=%b expected=%b", $time, abort_pulse, m_abort);
    end
    assert (busy === (m_mode != 0)) else begin
      miscompares++;
      $error("FAIL busy t=%0t observed=%b expected=%b", $time, busy, m_mode != 0);
    end
  endtask

  task automatic expect_count(input string tag, input int got, input int exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic a, input logic b);
    sens_out = a;
    sens_in  = b;
    @(posedge clk);
    if (rst_n) model_edge(a, b);
    #1 check();
  endtask

  task automatic hold(input logic a, input logic b, input int n);
    for (int i = 0; i < n; i++) step(a, b);
  endtask

  initial begin
    int e0, x0, a0, b0, lat;
    model_reset();

    // Reset held with both beams broken, then release: abort after 2+DEB+1 cycles.
    hold(1'b1, 1'b1, 5);
    rst_n = 1'b1;
    a0 = n_abort;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b1);
      if (abort_pulse && lat == 0) lat = i;
    end
    expect_count("reset_abort_latency", lat, 2 + DEB + 1);
    expect_count("reset_abort_count", n_abort - a0, 1);
    expect_count("wait_clr_busy", int'(busy), 1);
    hold(1'b0, 1'b0, 20);

    // Enter pass.
    e0 = n_enter; x0 = n_exit; a0 = n_abort;
    hold(1'b1, 1'b0, 20); hold(1'b1, 1'b1, 20); hold(1'b0, 1'b1, 20); hold(1'b0, 1'b0, 20);
    expect_count("enter_count", n_enter - e0, 1);
    expect_count("enter_no_exit", n_exit - x0, 0);
    expect_count("enter_no_abort", n_abort - a0, 0);

    // Exit pass, then backtrack that must produce nothing.
    e0 = n_enter; x0 = n_exit;
    hold(1'b0, 1'b1, 20); hold(1'b1, 1'b1, 20); hold(1'b1, 1'b0, 20); hold(1'b0, 1'b0, 20);
    expect_count("exit_count", n_exit - x0, 1);
    e0 = n_enter; x0 = n_exit; a0 = n_abort;
    hold(1'b1, 1'b0, 20); hold(1'b1, 1'b1, 20); hold(1'b1, 1'b0, 20); hold(1'b0, 1'b0, 20);
    expect_count("backtrack_pulses", (n_enter - e0) + (n_exit - x0) + (n_abort - a0), 0);

    // Glitch shorter than the debounce window.
    b0 = n_busy;
    hold(1'b1, 1'b0, 3); hold(1'b0, 1'b0, 15);
    expect_count("glitch_busy", n_busy - b0, 0);

    // Timeout while A stays broken.
    a0 = n_abort;
    hold(1'b1, 1'b0, 1200);
    expect_count("timeout_abort", n_abort - a0, 1);
    expect_count("timeout_busy_held", int'(busy), 1);
    hold(1'b0, 1'b0, 20);
    expect_count("timeout_cleared", int'(busy), 0);

    // Reset in the middle of an enter pass, while in E_B.
    e0 = n_enter; x0 = n_exit;
    hold(1'b1, 1'b0, 20); hold(1'b1, 1'b1, 20); hold(1'b0, 1'b1, 20);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check();
    expect_count("midreset_busy", int'(busy), 0);
    hold(1'b0, 1'b1, 5);
    rst_n = 1'b1;
    hold(1'b0, 1'b1, 20); hold(1'b0, 1'b0, 20);
    expect_count("midreset_no_enter", n_enter - e0, 0);
    expect_count("midreset_no_exit", n_exit - x0, 0);

    // Randomized beam patterns, mostly debounce-length or longer, some glitches.
    for (int s = 0; s < 300; s++) begin
      logic [1:0] pat;
      int len;
      pat = 2'($urandom_range(0, 3));
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 30));
      hold(pat[1], pat[0], len);
    end
    hold(1'b0, 1'b0, 30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
